// File: rtl/instr_pkg.sv
// Shared instruction-word layout for the encoder and decoder.
package instr_pkg;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_W    = 4;
  localparam int unsigned OPC_LSB  = OPC_MSB - OPC_W + 1;
  localparam int unsigned REG_W    = 3;
  localparam int unsigned RD_LSB   = 9;
  localparam int unsigned FLAG_BIT = 8;
  localparam int unsigned RA_LSB   = 5;
  localparam int unsigned RB_LSB   = 2;
  localparam int unsigned IMM_W    = 8;

  typedef logic [INSTR_W-1:0] instr_t;

  // FIFO payload: format tag alongside the packed word
  typedef struct packed {
    logic   is_imm;
    instr_t word;
  } enc_entry_t;

  // Register format leaves [1:0] at zero; immediate format ignores ra/rb.
  function automatic instr_t pack_instr(
    input logic [OPC_W-1:0] opc,
    input logic [REG_W-1:0] rd,
    input logic             flag,
    input logic [REG_W-1:0] ra,
    input logic [REG_W-1:0] rb,
    input logic [IMM_W-1:0] imm,
    input logic             is_imm
  );
    instr_t w;
    w                     = '0;
    w[OPC_LSB +: OPC_W]   = opc;
    w[RD_LSB +: REG_W]    = rd;
    w[FLAG_BIT]           = flag;
    if (is_imm) begin
      w[0 +: IMM_W]       = imm;
    end else begin
      w[RA_LSB +: REG_W]  = ra;
      w[RB_LSB +: REG_W]  = rb;
    end
    return w;
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Small synchronous FIFO buffering encoded instruction entries.
module enc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 17
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic             empty,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == FULL_LVL);
  assign empty   = (count == '0);
  // flush overrides any transfer presented in the same cycle
  assign do_wr   = wr_en && !full && !flush;
  assign do_rd   = rd_en && !empty && !flush;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset since the head is masked when empty
  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at power-of-two DEPTH
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// Packs register/immediate fields into 16-bit instruction words and buffers them.
module instruction_encoder
  import instr_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter logic [15:0] IMM_OPC_MASK = 16'hF000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [2:0]       in_rd,
  input  logic             in_flag,
  input  logic [2:0]       in_ra,
  input  logic [2:0]       in_rb,
  input  logic [7:0]       in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_instruct,
  output logic             out_is_imm,
  output logic [CNT_W-1:0] emit_count
);

  enc_entry_t enc_in;
  enc_entry_t enc_head;
  logic       fifo_full;
  logic       fifo_empty;

  // Encode fields at the FIFO input
  always_comb begin
    enc_in        = '0;
    enc_in.is_imm = IMM_OPC_MASK[in_opcode];
    enc_in.word   = pack_instr(in_opcode, in_rd, in_flag, in_ra, in_rb,
                               in_imm, enc_in.is_imm);
  end

  enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(enc_entry_t))
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .wr_en   (in_valid),
    .wr_data (enc_in),
    .full    (fifo_full),
    .rd_en   (out_ready),
    .empty   (fifo_empty),
    .rd_data (enc_head)
  );

  assign in_ready     = !fifo_full;
  assign out_valid    = !fifo_empty;
  assign out_instruct = enc_head.word;
  assign out_is_imm   = enc_head.is_imm;

  // Count words handed to the consumer; flush-cycle pops are not counted
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      emit_count <= '0;
    end else if (out_valid && out_ready && !flush) begin
      emit_count <= emit_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder.
module tb_instruction_encoder;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [3:0] opc;
    logic [2:0] rd;
    logic       flag;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] imm;
  } fields_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instruct;
  logic        out_is_imm;
  logic [15:0] emit_count;
  fields_t     drv;

  fields_t     sb[$];
  logic [15:0] exp_emit = '0;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clock = ~clock;

  instruction_encoder #(
    .DEPTH        (DEPTH),
    .IMM_OPC_MASK (16'hF000),
    .CNT_W        (16)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (drv.opc),
    .in_rd        (drv.rd),
    .in_flag      (drv.flag),
    .in_ra        (drv.ra),
    .in_rb        (drv.rb),
    .in_imm       (drv.imm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instruct (out_instruct),
    .out_is_imm   (out_is_imm),
    .emit_count   (emit_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic fields_t rand_fields();
    fields_t f;
    f.opc  = 4'($urandom);
    f.rd   = 3'($urandom);
    f.flag = 1'($urandom);
    f.ra   = 3'($urandom);
    f.rb   = 3'($urandom);
    f.imm  = 8'($urandom);
    return f;
  endfunction

  // Monitor: compare predicted state each cycle and retire popped words
  always @(negedge clock) begin
    fields_t f;
    logic    imm_fmt;
    if (!reset_n) begin
      sb.delete();
      exp_emit = '0;
    end else begin
      check("out_valid", out_valid, sb.size() != 0);
      check("in_ready", in_ready, sb.size() < DEPTH);
      check("emit_count", emit_count, exp_emit);
      if (!out_valid) begin
        check("empty_instr", out_instruct, 0);
        check("empty_is_imm", out_is_imm, 0);
      end
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready && sb.size() != 0) begin
          f = sb.pop_front();
          imm_fmt = (f.opc >= 4'hC);
          check("word", out_instruct,
                imm_fmt ? {f.opc, f.rd, f.flag, f.imm} : {f.opc, f.rd, f.flag, f.ra, f.rb, 2'b00});
          check("is_imm", out_is_imm, imm_fmt);
          check("dec_opc", out_instruct[15:12], f.opc);
          check("dec_rd", out_instruct[11:9], f.rd);
          check("dec_flag", out_instruct[8], f.flag);
          if (imm_fmt) begin
            check("dec_imm", out_instruct[7:0], f.imm);
          end else begin
            check("dec_ra", out_instruct[7:5], f.ra);
            check("dec_rb", out_instruct[4:2], f.rb);
            check("dec_pad", out_instruct[1:0], 0);
          end
          exp_emit = exp_emit + 16'd1;
        end
        if (in_valid && in_ready) sb.push_back(drv);
      end
    end
  end

  task automatic do_reset();
    @(posedge clock); #1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // Present one tuple and wait (bounded) for its acceptance edge
  task automatic push_word(input fields_t f);
    bit done;
    done = 0;
    drv = f;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock); #1;
        done = 1;
      end
    end
    in_valid = 1'b0;
    if (!done) check("push_timeout", 0, 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && out_valid; i++) begin
      @(posedge clock); #1;
    end
    out_ready = 1'b0;
    check("drained", out_valid, 0);
  endtask

  fields_t t1, t2;

  initial begin
    drv = '{default: '0};
    t1 = '{opc: 4'h2, rd: 3'd3, flag: 1'b1, ra: 3'd5, rb: 3'd6, imm: 8'h00};
    t2 = '{opc: 4'hD, rd: 3'd1, flag: 1'b0, ra: 3'd7, rb: 3'd7, imm: 8'hA5};

    // 1: reset state, then register format
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_instr", out_instruct, 0);
    check("rst_emit", emit_count, 0);
    push_word(t1);
    check("t1_valid", out_valid, 1);
    check("t1_word", out_instruct, 16'h27B8);
    check("t1_is_imm", out_is_imm, 0);
    out_ready = 1'b1;
    @(posedge clock); #1 out_ready = 1'b0;
    check("t1_emit", emit_count, 1);

    // 2: immediate format
    push_word(t2);
    check("t2_word", out_instruct, 16'hD2A5);
    check("t2_is_imm", out_is_imm, 1);
    drain();
    check("t2_emit", emit_count, 2);

    // 3: fill, hold the fifth word, then pop four in order
    do_reset();
    for (int i = 0; i < 4; i++) push_word(rand_fields());
    check("t3_full", in_ready, 0);
    drv = rand_fields();
    in_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("t3_held_ready", in_ready, 0);
    check("t3_held_valid", out_valid, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1 out_ready = 1'b0;
    check("t3_emit", emit_count, 4);
    check("t3_empty", out_valid, 0);
    push_word(drv);
    drain();

    // 4: streaming across pointer wrap with two preloaded
    do_reset();
    push_word(rand_fields());
    push_word(rand_fields());
    for (int i = 0; i < 20; i++) begin
      drv = rand_fields();
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clock); #1;
      check("t4_occ", dut.u_fifo.count, 2);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("t4_emit", emit_count, 20);
    drain();

    // 5: flush with three buffered and a push/pop presented
    do_reset();
    for (int i = 0; i < 4; i++) push_word(rand_fields());
    out_ready = 1'b1;
    @(posedge clock); #1 out_ready = 1'b0;
    drv = rand_fields();
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("t5_valid", out_valid, 0);
    check("t5_instr", out_instruct, 0);
    check("t5_ready", in_ready, 1);
    check("t5_emit", emit_count, 1);

    // 6: asynchronous reset while full
    do_reset();
    for (int i = 0; i < 4; i++) push_word(rand_fields());
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 out_ready = 1'b0;
    push_word(rand_fields());
    push_word(rand_fields());
    check("t6_full", in_ready, 0);
    check("t6_emit_pre", emit_count, 2);
    out_ready = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_emit", emit_count, 0);
    check("t6_instr", out_instruct, 0);
    check("t6_ready", in_ready, 1);
    out_ready = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    push_word(t1);
    check("t6_word", out_instruct, 16'h27B8);
    drain();

    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
